// File: rtl/time_display_scanner.sv
// Six-digit multiplexed common-anode 7-segment scanner for an HH:MM:SS counter.
// The time is snapshotted once per scan frame so the digits never tear across a rollover.
module time_display_scanner #(
    parameter int SCAN_DIV   = 4,
    parameter bit LEAD_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] H_reg,
    input  logic [5:0] M_reg,
    input  logic [5:0] S_reg,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] dig_en_n,
    output logic       frame_done
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       dig_idx_q, dig_idx_d;
    logic [4:0]       snap_h_q, snap_h_d;
    logic [5:0]       snap_m_q, snap_m_d;
    logic [5:0]       snap_s_q, snap_s_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic [5:0]       dig_en_n_q, dig_en_n_d;
    logic             frame_done_q, frame_done_d;

    logic             div_last;
    logic             h_ok, m_ok, s_ok;
    logic [3:0]       h_tens, h_units, m_tens, m_units, s_tens, s_units;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    always_comb begin
        div_last     = (div_cnt_q == DIV_LAST);
        div_cnt_d    = div_last ? '0 : div_cnt_q + 1'b1;
        dig_idx_d    = dig_idx_q;
        if (div_last) begin
            dig_idx_d = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
        end

        // The snapshot and frame_done share one edge: the last cycle of digit 5.
        frame_done_d = div_last && (dig_idx_q == 3'd5);
        snap_h_d     = frame_done_d ? H_reg : snap_h_q;
        snap_m_d     = frame_done_d ? M_reg : snap_m_q;
        snap_s_d     = frame_done_d ? S_reg : snap_s_q;

        h_ok    = (snap_h_q <= 5'd23);
        m_ok    = (snap_m_q <= 6'd59);
        s_ok    = (snap_s_q <= 6'd59);
        h_tens  = 4'({1'b0, snap_h_q} / 6'd10);
        h_units = 4'({1'b0, snap_h_q} % 6'd10);
        m_tens  = 4'(snap_m_q / 6'd10);
        m_units = 4'(snap_m_q % 6'd10);
        s_tens  = 4'(snap_s_q / 6'd10);
        s_units = 4'(snap_s_q % 6'd10);

        seg_n_d = SEG_BLANK;
        case (dig_idx_q)
            3'd0: begin
                if (!h_ok)
                    seg_n_d = SEG_DASH;
                else if (LEAD_BLANK && (h_tens == 4'd0))
                    seg_n_d = SEG_BLANK;
                else
                    seg_n_d = seg_code(h_tens);
            end
            3'd1:    seg_n_d = h_ok ? seg_code(h_units) : SEG_DASH;
            3'd2:    seg_n_d = m_ok ? seg_code(m_tens)  : SEG_DASH;
            3'd3:    seg_n_d = m_ok ? seg_code(m_units) : SEG_DASH;
            3'd4:    seg_n_d = s_ok ? seg_code(s_tens)  : SEG_DASH;
            3'd5:    seg_n_d = s_ok ? seg_code(s_units) : SEG_DASH;
            default: seg_n_d = SEG_BLANK;
        endcase

        // Colon DPs sit after H units and M units and blink with the seconds LSB.
        dp_n_d     = !(((dig_idx_q == 3'd1) || (dig_idx_q == 3'd3)) && !snap_s_q[0]);
        dig_en_n_d = ~(6'b000001 << dig_idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            dig_idx_q    <= 3'd0;
            snap_h_q     <= 5'd0;
            snap_m_q     <= 6'd0;
            snap_s_q     <= 6'd0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            dig_en_n_q   <= 6'h3F;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_idx_q    <= dig_idx_d;
            snap_h_q     <= snap_h_d;
            snap_m_q     <= snap_m_d;
            snap_s_q     <= snap_s_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            dig_en_n_q   <= dig_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign dig_en_n   = dig_en_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Directed bench for time_display_scanner: two instances (LEAD_BLANK off/on) share the stimulus.
module tb_time_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] hReg = 5'd0;
    logic [5:0] mReg = 6'd0;
    logic [5:0] sReg = 6'd0;

    logic [6:0] segN, lbSegN;
    logic       dpN, lbDpN;
    logic [5:0] digEnN, lbDigEnN;
    logic       frameDone, lbFrameDone;

    int vecCount  = 0;
    int missCount = 0;

    logic [5:0] digEnTab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic       colonTab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    time_display_scanner #(.SCAN_DIV(4), .LEAD_BLANK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .H_reg(hReg), .M_reg(mReg), .S_reg(sReg),
        .seg_n(segN), .dp_n(dpN), .dig_en_n(digEnN), .frame_done(frameDone)
    );

    time_display_scanner #(.SCAN_DIV(4), .LEAD_BLANK(1'b1)) dutLb (
        .clk(clk), .rst_n(rst_n), .H_reg(hReg), .M_reg(mReg), .S_reg(sReg),
        .seg_n(lbSegN), .dp_n(lbDpN), .dig_en_n(lbDigEnN), .frame_done(lbFrameDone)
    );

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Release lands on a negedge, so the next posedge is edge 1.
    task automatic resetDut(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        rst_n = 1'b0;
        hReg = h; mReg = m; sReg = s;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hReg = 5'd0; mReg = 6'd0; sReg = 6'd0;
        repeat (5) @(negedge clk);
        vecCount++;
        if (digEnN !== 6'h3F) begin missCount++; $display("[TB] FAIL reset_dig_en got %h want 3f", digEnN); end
        vecCount++;
        if (segN !== 7'h7F) begin missCount++; $display("[TB] FAIL reset_seg got %h want 7f", segN); end
        vecCount++;
        if (dpN !== 1'b1) begin missCount++; $display("[TB] FAIL reset_dp got %b want 1", dpN); end
        vecCount++;
        if (frameDone !== 1'b0) begin missCount++; $display("[TB] FAIL reset_frame_done got %b want 0", frameDone); end
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            int e;
            waitEdges(1);
            e = (k - 1) / 4;
            vecCount++;
            if (digEnN !== digEnTab[e]) begin missCount++; $display("[TB] FAIL scan_dig_en edge %0d got %h want %h", k, digEnN, digEnTab[e]); end
            vecCount++;
            if (segN !== 7'h40) begin missCount++; $display("[TB] FAIL scan_seg edge %0d got %h want 40", k, segN); end
            vecCount++;
            if (dpN !== colonTab[e]) begin missCount++; $display("[TB] FAIL scan_dp edge %0d got %b want %b", k, dpN, colonTab[e]); end
            vecCount++;
            if (frameDone !== (k == 24)) begin missCount++; $display("[TB] FAIL scan_frame_done edge %0d got %b want %b", k, frameDone, (k == 24)); end
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] segTab [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        resetDut(5'd12, 6'd34, 6'd56);
        for (int k = 1; k <= 24; k++) begin
            waitEdges(1);
            vecCount++;
            if (frameDone !== (k == 24)) begin missCount++; $display("[TB] FAIL snap_frame_done edge %0d got %b want %b", k, frameDone, (k == 24)); end
        end
        for (int e = 0; e < 6; e++) begin
            waitEdges(e == 0 ? 1 : 4);
            vecCount++;
            if (digEnN !== digEnTab[e]) begin missCount++; $display("[TB] FAIL snap_dig_en digit %0d got %h want %h", e, digEnN, digEnTab[e]); end
            vecCount++;
            if (segN !== segTab[e]) begin missCount++; $display("[TB] FAIL snap_seg digit %0d got %h want %h", e, segN, segTab[e]); end
            vecCount++;
            if (dpN !== colonTab[e]) begin missCount++; $display("[TB] FAIL snap_dp digit %0d got %b want %b", e, dpN, colonTab[e]); end
            vecCount++;
            if (lbSegN !== segTab[e]) begin missCount++; $display("[TB] FAIL snap_lb_seg digit %0d got %h want %h", e, lbSegN, segTab[e]); end
        end
    endtask

    task automatic test_coherence();
        logic [6:0] oldTab [6] = '{7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10};
        resetDut(5'd23, 6'd59, 6'd59);
        waitEdges(24);
        vecCount++;
        if (frameDone !== 1'b1) begin missCount++; $display("[TB] FAIL coh_frame_done1 got %b want 1", frameDone); end
        for (int e = 0; e < 6; e++) begin
            waitEdges(e == 0 ? 1 : 4);
            vecCount++;
            if (segN !== oldTab[e]) begin missCount++; $display("[TB] FAIL coh_old_seg digit %0d got %h want %h", e, segN, oldTab[e]); end
            vecCount++;
            if (dpN !== 1'b1) begin missCount++; $display("[TB] FAIL coh_old_dp digit %0d got %b want 1", e, dpN); end
            if (e == 0) begin
                hReg = 5'd0; mReg = 6'd0; sReg = 6'd0;
            end
        end
        waitEdges(3);
        vecCount++;
        if (frameDone !== 1'b1) begin missCount++; $display("[TB] FAIL coh_frame_done2 got %b want 1", frameDone); end
        for (int e = 0; e < 6; e++) begin
            waitEdges(e == 0 ? 1 : 4);
            vecCount++;
            if (segN !== 7'h40) begin missCount++; $display("[TB] FAIL coh_new_seg digit %0d got %h want 40", e, segN); end
            vecCount++;
            if (dpN !== colonTab[e]) begin missCount++; $display("[TB] FAIL coh_new_dp digit %0d got %b want %b", e, dpN, colonTab[e]); end
        end
    endtask

    task automatic test_range();
        logic [6:0] segTab [6] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h78};
        resetDut(5'd25, 6'd60, 6'd7);
        waitEdges(24);
        for (int e = 0; e < 6; e++) begin
            waitEdges(e == 0 ? 1 : 4);
            vecCount++;
            if (segN !== segTab[e]) begin missCount++; $display("[TB] FAIL range_seg digit %0d got %h want %h", e, segN, segTab[e]); end
            vecCount++;
            if (lbSegN !== segTab[e]) begin missCount++; $display("[TB] FAIL range_lb_seg digit %0d got %h want %h", e, lbSegN, segTab[e]); end
            vecCount++;
            if (dpN !== 1'b1) begin missCount++; $display("[TB] FAIL range_dp digit %0d got %b want 1", e, dpN); end
        end
    endtask

    task automatic test_lead_blank();
        logic [6:0] lbTab [6] = '{7'h7F, 7'h78, 7'h40, 7'h12, 7'h40, 7'h10};
        resetDut(5'd7, 6'd5, 6'd9);
        waitEdges(24);
        for (int e = 0; e < 6; e++) begin
            waitEdges(e == 0 ? 1 : 4);
            vecCount++;
            if (lbSegN !== lbTab[e]) begin missCount++; $display("[TB] FAIL lb_seg digit %0d got %h want %h", e, lbSegN, lbTab[e]); end
            vecCount++;
            if (lbDpN !== 1'b1) begin missCount++; $display("[TB] FAIL lb_dp digit %0d got %b want 1", e, lbDpN); end
            if (e == 0) begin
                vecCount++;
                if (segN !== 7'h40) begin missCount++; $display("[TB] FAIL nolb_h_tens got %h want 40", segN); end
            end
        end
        resetDut(5'd10, 6'd0, 6'd0);
        waitEdges(25);
        vecCount++;
        if (lbSegN !== 7'h79) begin missCount++; $display("[TB] FAIL lb10_h_tens got %h want 79", lbSegN); end
        waitEdges(4);
        vecCount++;
        if (lbSegN !== 7'h40) begin missCount++; $display("[TB] FAIL lb10_h_units got %h want 40", lbSegN); end
    endtask

    task automatic test_async_reset();
        resetDut(5'd12, 6'd34, 6'd56);
        waitEdges(13);
        vecCount++;
        if (digEnN !== 6'h37) begin missCount++; $display("[TB] FAIL arst_pre_dig_en got %h want 37", digEnN); end
        #2;
        rst_n = 1'b0;
        #1;
        vecCount++;
        if (digEnN !== 6'h3F) begin missCount++; $display("[TB] FAIL arst_dig_en got %h want 3f", digEnN); end
        vecCount++;
        if (segN !== 7'h7F) begin missCount++; $display("[TB] FAIL arst_seg got %h want 7f", segN); end
        vecCount++;
        if (dpN !== 1'b1) begin missCount++; $display("[TB] FAIL arst_dp got %b want 1", dpN); end
        vecCount++;
        if (frameDone !== 1'b0) begin missCount++; $display("[TB] FAIL arst_frame_done got %b want 0", frameDone); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            waitEdges(1);
            if (k == 1) begin
                vecCount++;
                if (digEnN !== 6'h3E) begin missCount++; $display("[TB] FAIL arst_restart_dig_en got %h want 3e", digEnN); end
                vecCount++;
                if (segN !== 7'h40) begin missCount++; $display("[TB] FAIL arst_restart_seg got %h want 40", segN); end
            end
            vecCount++;
            if (frameDone !== (k == 24)) begin missCount++; $display("[TB] FAIL arst_frame_done edge %0d got %b want %b", k, frameDone, (k == 24)); end
        end
        waitEdges(1);
        vecCount++;
        if (segN !== 7'h79) begin missCount++; $display("[TB] FAIL arst_new_seg got %h want 79", segN); end
    endtask

    initial begin
        $display("[TB] starting time_display_scanner bench");
        test_reset();
        test_snapshot();
        test_coherence();
        test_range();
        test_lead_blank();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
